// File: rtl/hdu_scoreboard.sv
// Register scoreboard for the ID stage: tracks per-register result latency
// and raises a combinational stall on RAW/WAW hazards against pending results.

module hdu_sb_entry #(
    parameter int LAT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 load,
    input  logic [LAT_WIDTH-1:0] lat,
    output logic                 busy
);
    logic [LAT_WIDTH-1:0] cnt, cntNext;

    // A load takes priority over the decrement; freeze holds the countdown.
    always_comb begin
        cntNext = cnt;
        if (!freeze) begin
            if (load)
                cntNext = lat;
            else if (cnt != '0)
                cntNext = cnt - {{(LAT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // busy is registered alongside cnt so it always mirrors (cnt != 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else begin
            cnt  <= cntNext;
            busy <= (cntNext != '0);
        end
    end
endmodule

module hdu_scoreboard #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int LAT_WIDTH     = 3,
    parameter int CNT_WIDTH     = 32,
    localparam int NUM_REGS     = 2**RF_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RF_ADDR_WIDTH-1:0] ifidRs1,
    input  logic [RF_ADDR_WIDTH-1:0] ifidRs2,
    input  logic                     ifidRs1Used,
    input  logic                     ifidRs2Used,
    input  logic [RF_ADDR_WIDTH-1:0] ifidRd,
    input  logic                     ifidRdWrite,
    input  logic [LAT_WIDTH-1:0]     ifidLat,
    input  logic                     ifidValid,
    input  logic                     flush,
    input  logic                     freeze,
    output logic                     stall,
    output logic [NUM_REGS-1:0]      busyMask,
    output logic [CNT_WIDTH-1:0]     stallCount
);
    logic raw, waw, issue;

    assign raw   = (ifidRs1Used && busyMask[ifidRs1]) || (ifidRs2Used && busyMask[ifidRs2]);
    assign waw   = ifidRdWrite && (ifidRd != '0) && busyMask[ifidRd];
    assign stall = ifidValid && !flush && (raw || waw);
    assign issue = ifidValid && !flush && !stall && !freeze;

    // x0 is hardwired: never reserved, never busy.
    assign busyMask[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : gEntry
        hdu_sb_entry #(.LAT_WIDTH(LAT_WIDTH)) uEntry (
            .clk    (clk),
            .rst    (rst),
            .freeze (freeze),
            .load   (issue && ifidRdWrite && (ifidRd == RF_ADDR_WIDTH'(r))),
            .lat    (ifidLat),
            .busy   (busyMask[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            stallCount <= '0;
        else if (stall && (stallCount != '1))
            stallCount <= stallCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
endmodule

// File: tb/tb_hdu_scoreboard.sv
// Bench for hdu_scoreboard: directed vector table followed by random traffic,
// both checked against a per-register "cycles until ready" reference model.

module tb_hdu_scoreboard;
    localparam int AW = 5;
    localparam int LW = 3;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ifidRs1, ifidRs2, ifidRd;
    logic          ifidRs1Used, ifidRs2Used, ifidRdWrite, ifidValid, flush, freeze;
    logic [LW-1:0] ifidLat;
    logic          stall, stallS;
    logic [NR-1:0] busyMask, busyMaskS;
    logic [31:0]   stallCount;
    logic [1:0]    stallCountS;

    hdu_scoreboard #(.RF_ADDR_WIDTH(AW), .LAT_WIDTH(LW), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ifidRs1(ifidRs1), .ifidRs2(ifidRs2),
        .ifidRs1Used(ifidRs1Used), .ifidRs2Used(ifidRs2Used), .ifidRd(ifidRd),
        .ifidRdWrite(ifidRdWrite), .ifidLat(ifidLat), .ifidValid(ifidValid),
        .flush(flush), .freeze(freeze), .stall(stall), .busyMask(busyMask),
        .stallCount(stallCount)
    );

    // Narrow-counter instance to reach stall-counter saturation quickly.
    hdu_scoreboard #(.RF_ADDR_WIDTH(AW), .LAT_WIDTH(LW), .CNT_WIDTH(2)) dutSmall (
        .clk(clk), .rst(rst), .ifidRs1(ifidRs1), .ifidRs2(ifidRs2),
        .ifidRs1Used(ifidRs1Used), .ifidRs2Used(ifidRs2Used), .ifidRd(ifidRd),
        .ifidRdWrite(ifidRdWrite), .ifidLat(ifidLat), .ifidValid(ifidValid),
        .flush(flush), .freeze(freeze), .stall(stallS), .busyMask(busyMaskS),
        .stallCount(stallCountS)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [AW-1:0] rs1, rs2, rd;
        logic          u1, u2, wr;
        logic [LW-1:0] lat;
        logic          valid, flush, freeze;
        logic          expStall;
    } vec_t;

    vec_t vecs[$];
    int   nChecks = 0;
    int   nFail   = 0;

    // Reference: remaining cycles until each register's result is ready.
    int     rem[NR];
    longint sc;

    function automatic logic mStall();
        logic raw, waw;
        raw = (ifidRs1Used && rem[ifidRs1] > 0) || (ifidRs2Used && rem[ifidRs2] > 0);
        waw = ifidRdWrite && ifidRd != 0 && rem[ifidRd] > 0;
        return ifidValid && !flush && (raw || waw);
    endfunction

    function automatic logic [NR-1:0] mBusy();
        logic [NR-1:0] b;
        for (int r = 0; r < NR; r++) b[r] = (rem[r] > 0);
        return b;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < NR; r++) rem[r] = 0;
        sc = 0;
    endtask

    task automatic modelStep();
        logic st;
        st = mStall();
        if (rst) begin
            modelReset();
        end else begin
            if (!freeze) begin
                for (int r = 0; r < NR; r++) if (rem[r] > 0) rem[r]--;
                if (ifidValid && !flush && !st && ifidRdWrite && ifidRd != 0)
                    rem[ifidRd] = int'(ifidLat);
            end
            if (st && sc < 64'hFFFF_FFFF) sc++;
        end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; ifidRs1 = v.rs1; ifidRs2 = v.rs2; ifidRd = v.rd;
        ifidRs1Used = v.u1; ifidRs2Used = v.u2; ifidRdWrite = v.wr;
        ifidLat = v.lat; ifidValid = v.valid; flush = v.flush; freeze = v.freeze;
    endtask

    task automatic runCycle(string tag, bit useExp, logic expStall);
        longint scSmall;
        @(negedge clk);
        scSmall = (sc > 3) ? 3 : sc;
        check({tag, ".stall"}, 64'(stall), 64'(mStall()));
        if (useExp) check({tag, ".stallTbl"}, 64'(stall), 64'(expStall));
        check({tag, ".busyMask"}, 64'(busyMask), 64'(mBusy()));
        check({tag, ".stallCount"}, 64'(stallCount), 64'(sc));
        check({tag, ".stallCountSat"}, 64'(stallCountS), 64'(scSmall));
        @(posedge clk);
        modelStep();
        #1;
    endtask

    function automatic vec_t mk(logic r, int rs1, int rs2, logic u1, logic u2,
                                int rd, logic wr, int lat, logic fl, logic fz, logic exp);
        vec_t v;
        v.rst = r; v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.u1 = u1; v.u2 = u2;
        v.rd = AW'(rd); v.wr = wr; v.lat = LW'(lat); v.valid = 1'b1;
        v.flush = fl; v.freeze = fz; v.expStall = exp;
        return v;
    endfunction

    initial begin
        //              rst rs1 rs2 u1 u2 rd wr lat fl fz exp
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0)); // load x5
        vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1)); // load-use stall
        vecs.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 7, 1, 3, 0, 0, 0)); // x7 lat 3
        vecs.push_back(mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0)); // load to x0
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4, 1, 2, 0, 0, 0)); // x4 lat 2
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0, 0, 1, 1)); // frozen
        vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 1, 2, 0, 0, 0)); // x9 lat 2
        vecs.push_back(mk(0, 9, 0, 1, 0, 0, 0, 0, 1, 0, 0)); // flushed
        vecs.push_back(mk(0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1)); // x9 still busy
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 1, 3, 0, 0, 0));
        vecs.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1)); // reset mid-countdown
        vecs.push_back(mk(0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0)); // x3 lat 1
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 2, 0, 0, 1)); // WAW stall
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 6, 1, 2, 0, 0, 0)); // x6 lat 2
        vecs.push_back(mk(0, 6, 6, 0, 1, 0, 0, 0, 0, 0, 1)); // rs2 only used
        vecs.push_back(mk(0, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0)); // no source used

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        modelReset();
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            runCycle($sformatf("vec%0d", i), 1'b1, vecs[i].expStall);
        end

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            ifidRs1     = AW'($urandom_range(0, 7));
            ifidRs2     = AW'($urandom_range(0, 7));
            ifidRd      = AW'($urandom_range(0, 7));
            ifidRs1Used = 1'($urandom_range(0, 1));
            ifidRs2Used = 1'($urandom_range(0, 1));
            ifidRdWrite = ($urandom_range(0, 3) != 0);
            ifidLat     = LW'($urandom_range(0, 7));
            ifidValid   = ($urandom_range(0, 7) != 0);
            flush       = ($urandom_range(0, 7) == 0);
            freeze      = ($urandom_range(0, 5) == 0);
            runCycle($sformatf("rnd%0d", i), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/hdu_scoreboard.md
HDU_SCOREBOARD -- requirements
Module: hdu_scoreboard

Interface
REQ-001 The block SHALL have parameter RF_ADDR_WIDTH, default 5, register-file address width (NUM_REGS = 2**RF_ADDR_WIDTH).
REQ-002 The block SHALL have parameter LAT_WIDTH, default 3, width of the result-latency field.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 32, width of the stall performance counter.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port ifidRs1, input, RF_ADDR_WIDTH: source register 1 of the instruction in ID.
REQ-008 Port ifidRs2, input, RF_ADDR_WIDTH: source register 2 of the instruction in ID.
REQ-009 Port ifidRs1Used, input, 1: instruction reads rs1.
REQ-010 Port ifidRs2Used, input, 1: instruction reads rs2.
REQ-011 Port ifidRd, input, RF_ADDR_WIDTH: destination register of the instruction in ID.
REQ-012 Port ifidRdWrite, input, 1: instruction writes rd.
REQ-013 Port ifidLat, input, LAT_WIDTH: cycles until the result is forwardable (0 = ALU-class, 1 = classic load).
REQ-014 Port ifidValid, input, 1: ID holds a valid instruction.
REQ-015 Port flush, input, 1: current ID instruction is squashed this cycle.
REQ-016 Port freeze, input, 1: back end held (e.g. memory wait); scoreboard does not advance.
REQ-017 Port stall, output, 1: combinational; stall PC and IF/ID, bubble ID/EX.
REQ-018 Port busyMask, output, NUM_REGS: registered; bit r = 1 when register r has a pending result.
REQ-019 Port stallCount, output, CNT_WIDTH: registered count of stall cycles.

Function
REQ-020 Per register r, the block SHALL hold a countdown cnt[r] of LAT_WIDTH bits; busyMask[r] = (cnt[r] != 0).
REQ-021 cnt[0] SHALL always be 0; busyMask[0] SHALL always be 0.
REQ-022 raw SHALL = (ifidRs1Used && cnt[ifidRs1] != 0) || (ifidRs2Used && cnt[ifidRs2] != 0).
REQ-023 waw SHALL = ifidRdWrite && ifidRd != 0 && cnt[ifidRd] != 0.
REQ-024 stall SHALL = ifidValid && !flush && (raw || waw), evaluated combinationally from current-cycle state and inputs.
REQ-025 issue SHALL = ifidValid && !flush && !stall && !freeze.
REQ-026 When freeze = 0, every nonzero cnt[r] SHALL decrement by 1 per cycle.
REQ-027 When issue && ifidRdWrite && ifidRd != 0, cnt[ifidRd] SHALL load ifidLat at the clock edge; the load overrides the decrement of that entry.
REQ-028 ifidLat = 0 SHALL leave cnt[ifidRd] at 0 (no reservation).
REQ-029 When freeze = 1, all cnt[r] SHALL hold and no reservation is recorded; stall is still driven per REQ-024.
REQ-030 flush = 1 SHALL force stall = 0 and block reservation for that cycle; already-reserved entries keep counting down.
REQ-031 stallCount SHALL increment by 1 on each cycle with stall = 1, saturating at 2**CNT_WIDTH-1.
REQ-032 With ifidLat = 1 for loads and 0 otherwise, behaviour SHALL equal the classic load-use rule: exactly one stall cycle for a dependent instruction immediately following a load, none otherwise.

Reset
REQ-033 On rst = 1 at a clock edge, all cnt[r], busyMask and stallCount SHALL be 0; rst SHALL override issue, freeze and decrement.
REQ-034 After reset, stall SHALL be 0 for any input combination until a reservation is made.

Verification
REQ-035 Load x5 (lat=1), next instr reads x5 as rs1 -> stall=1 for 1 cycle, then 0; stallCount=1.
REQ-036 Op writes x7 with lat=3, dependent reads x7 next cycle -> stall=1 for 3 cycles; busyMask[7] falls on the 3rd edge after issue.
REQ-037 Load to x0 (lat=1), next reads x0 -> stall=0; busyMask=0.
REQ-038 x4 reserved lat=2, freeze=1 for 4 cycles with dependent in ID -> stall held at 1 for 4 cycles, cnt[4] stays 2; after freeze drops, 2 more stall cycles.
REQ-039 x9 reserved lat=2, flush=1 with dependent in ID -> stall=0 that cycle, x9 still busy next cycle; rst mid-countdown -> busyMask=0, stallCount=0 next cycle.
REQ-040 Instr writes x3 (lat=2) while cnt[3]=1 -> waw stall=1; rs1=rs2=x6 with only rs2Used=1 and x6 busy -> stall=1; rs2Used=0 -> stall=0.
